// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and transmitter FSM states.
// Also used by the future receiver, so nothing here is TX-specific except the state enum.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered occupancy count; a push is visible to the read side one edge later.
// Pushes are dropped while full and pops ignored while empty; push+pop together leaves the count unchanged.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign o_full     = (count == FULL_CNT);
    assign o_empty    = (count == '0);
    assign o_count    = count;
    assign o_pop_data = mem[rd_ptr];
    assign do_push    = i_push && !o_full;
    assign do_pop     = i_pop && !o_empty;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO; start bit begins the edge after the pop, frames run back-to-back.
// o_ready drops only when the registered FIFO count reaches FIFO_DEPTH.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_BITS-1:0]          i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DIV_WIDTH-1:0]          i_clks_per_bit,
    output logic                          o_out,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    uart_tx_state_t         state;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic [DIV_WIDTH-1:0]   timer;
    logic [BIT_W-1:0]       bit_idx;
    logic                   stop_idx;

    logic [DATA_BITS-1:0]   fifo_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   bit_done;
    logic                   last_stop;
    logic                   pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_valid),
        .i_push_data (i_data),
        .i_pop       (pop),
        .o_pop_data  (fifo_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (o_fifo_count)
    );

    assign o_ready   = !fifo_full;
    assign o_busy    = (state != ST_IDLE) || !fifo_empty;
    assign div_eff   = (i_clks_per_bit == '0) ? ONE : i_clks_per_bit;
    assign bit_done  = (timer == '0);
    assign last_stop = (state == ST_STOP) && bit_done && (stop_idx == LAST_STOP);
    // Popping at the end of the last stop bit lets the next start bit follow with no idle cycle.
    assign pop       = !fifo_empty && ((state == ST_IDLE) || last_stop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            o_out    <= 1'b1;
            shreg    <= '0;
            par_bit  <= 1'b0;
            div_q    <= ONE;
            timer    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else if (pop) begin
            shreg    <= fifo_data;
            par_bit  <= (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
            div_q    <= div_eff;
            timer    <= div_eff - ONE;
            state    <= ST_START;
            o_out    <= 1'b0;
        end else if (state != ST_IDLE) begin
            if (!bit_done) begin
                timer <= timer - ONE;
            end else begin
                timer <= div_q - ONE;
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        o_out   <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                    end
                    ST_DATA: begin
                        if (bit_idx == LAST_BIT) begin
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                o_out <= par_bit;
                            end else begin
                                state    <= ST_STOP;
                                o_out    <= 1'b1;
                                stop_idx <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            o_out   <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state    <= ST_STOP;
                        o_out    <= 1'b1;
                        stop_idx <= 1'b0;
                    end
                    ST_STOP: begin
                        if (stop_idx == LAST_STOP) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        o_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations driven from a shared clock/reset, line checked cycle by cycle.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  din   [4];
    logic        valid [4];
    logic        ready [4];
    logic        out   [4];
    logic        busy  [4];
    logic [2:0]  cnt   [4];
    logic [15:0] div   [4];

    int nb [4] = '{8, 8, 9, 5};
    int pm [4] = '{0, 2, 1, 0};
    int sb [4] = '{1, 2, 1, 1};

    int total  = 0;
    int passed = 0;

    logic [8:0] push_q [$];
    bit         exp_q  [$];
    int chg_t, chg_div;
    int first_bad, acc_n, acc_before_block, ready_rise_t, block_count;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u0 (
        .i_clk(clk), .i_rst(rst), .i_data(din[0][7:0]), .i_valid(valid[0]), .o_ready(ready[0]),
        .i_clks_per_bit(div[0]), .o_out(out[0]), .o_busy(busy[0]), .o_fifo_count(cnt[0]));
    uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u1 (
        .i_clk(clk), .i_rst(rst), .i_data(din[1][7:0]), .i_valid(valid[1]), .o_ready(ready[1]),
        .i_clks_per_bit(div[1]), .o_out(out[1]), .o_busy(busy[1]), .o_fifo_count(cnt[1]));
    uart_tx_fifo #(.DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u2 (
        .i_clk(clk), .i_rst(rst), .i_data(din[2]), .i_valid(valid[2]), .o_ready(ready[2]),
        .i_clks_per_bit(div[2]), .o_out(out[2]), .o_busy(busy[2]), .o_fifo_count(cnt[2]));
    uart_tx_fifo #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u3 (
        .i_clk(clk), .i_rst(rst), .i_data(din[3][4:0]), .i_valid(valid[3]), .o_ready(ready[3]),
        .i_clks_per_bit(div[3]), .o_out(out[3]), .o_busy(busy[3]), .o_fifo_count(cnt[3]));

    // Reference frame: start, data LSB first, parity from a ones count, stop bits; each bit held d cycles.
    task automatic add_frame(input int i, input logic [8:0] w, input int d);
        bit f [$];
        int dd   = (d < 1) ? 1 : d;
        int ones = 0;
        f.push_back(1'b0);
        for (int b = 0; b < nb[i]; b++) begin
            f.push_back(w[b]);
            ones += int'(w[b]);
        end
        if (pm[i] == 2) f.push_back(ones % 2 == 1);
        if (pm[i] == 1) f.push_back(ones % 2 == 0);
        for (int s = 0; s < sb[i]; s++) f.push_back(1'b1);
        foreach (f[k]) repeat (dd) exp_q.push_back(f[k]);
    endtask

    // Sample t is taken at the falling edge after rising edge k+t, k being the first accept edge.
    task automatic play(input int i, input int ncyc);
        bit seen = 0;
        bit was_blocked = 0;
        bit e_bit;
        int j0 = 0;
        int t;
        first_bad = -1; acc_n = 0; acc_before_block = -1; ready_rise_t = -1; block_count = -1;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            if (seen) begin
                t = j - j0 - 1;
                e_bit = (t < exp_q.size()) ? exp_q[t] : 1'b1;
                if (out[i] !== e_bit && first_bad < 0) first_bad = t;
                if (t == chg_t) div[i] = 16'(chg_div);
                if (!ready[i] && !was_blocked) begin
                    was_blocked = 1;
                    acc_before_block = acc_n;
                    block_count = int'(cnt[i]);
                end else if (ready[i] && was_blocked && ready_rise_t < 0) begin
                    ready_rise_t = t;
                end
            end
            if (push_q.size() > 0) begin
                valid[i] = 1'b1;
                din[i] = push_q[0];
                if (ready[i]) begin
                    if (!seen) begin
                        seen = 1;
                        j0 = j;
                    end
                    acc_n++;
                    void'(push_q.pop_front());
                end
            end else begin
                valid[i] = 1'b0;
            end
        end
        valid[i] = 1'b0;
        chg_t = -1;
    endtask

    task automatic start_stream();
        exp_q.delete();
        push_q.delete();
        exp_q.push_back(1'b1);
        chg_t = -1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            din[i] = '0; valid[i] = 1'b0; div[i] = 16'd4;
        end
        chg_t = -1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++; if (out[i] !== 1'b1) $display("FAIL reset_out[%0d] got %b want 1", i, out[i]); else passed++;
            total++; if (ready[i] !== 1'b1) $display("FAIL reset_ready[%0d] got %b want 1", i, ready[i]); else passed++;
            total++; if (busy[i] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", i, busy[i]); else passed++;
            total++; if (cnt[i] !== 3'd0) $display("FAIL reset_count[%0d] got %0d want 0", i, cnt[i]); else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        start_stream();
        div[0] = 16'd4;
        push_q.push_back(9'h0A5);
        add_frame(0, 9'h0A5, 4);
        play(0, 50);
        total++; if (first_bad !== -1) $display("FAIL basic_line first bad sample %0d want none", first_bad); else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy[0]); else passed++;
    endtask

    task automatic test_parity();
        logic [8:0] w;
        start_stream();
        w = 9'($urandom_range(0, 255));
        div[1] = 16'd3;
        push_q.push_back(9'h007); add_frame(1, 9'h007, 3);
        push_q.push_back(w);      add_frame(1, w, 3);
        play(1, 85);
        total++; if (first_bad !== -1) $display("FAIL even_parity_line first bad sample %0d want none", first_bad); else passed++;
        total++; if (busy[1] !== 1'b0) $display("FAIL even_parity_busy got %b want 0", busy[1]); else passed++;
        start_stream();
        w = 9'($urandom_range(0, 511));
        div[2] = 16'd4;
        push_q.push_back(9'h007); add_frame(2, 9'h007, 4);
        push_q.push_back(w);      add_frame(2, w, 4);
        play(2, 110);
        total++; if (first_bad !== -1) $display("FAIL odd_parity_line first bad sample %0d want none", first_bad); else passed++;
    endtask

    task automatic test_fifo_full();
        logic [8:0] w;
        start_stream();
        div[0] = 16'd16;
        for (int n = 0; n < 6; n++) begin
            w = 9'($urandom_range(0, 255));
            push_q.push_back(w);
            add_frame(0, w, 16);
        end
        play(0, 1 + 6 * 160 + 20);
        total++; if (acc_before_block !== 5) $display("FAIL full_accepts got %0d want 5", acc_before_block); else passed++;
        total++; if (block_count !== 4) $display("FAIL full_count got %0d want 4", block_count); else passed++;
        total++; if (ready_rise_t !== 161) $display("FAIL full_ready_rise sample %0d want 161", ready_rise_t); else passed++;
        total++; if (acc_n !== 6) $display("FAIL full_total_accepts got %0d want 6", acc_n); else passed++;
        total++; if (first_bad !== -1) $display("FAIL full_line first bad sample %0d want none", first_bad); else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL full_busy_end got %b want 0", busy[0]); else passed++;
    endtask

    task automatic test_div_change();
        logic [8:0] w0, w1;
        start_stream();
        w0 = 9'($urandom_range(0, 255));
        w1 = 9'($urandom_range(0, 255));
        div[0] = 16'd4;
        push_q.push_back(w0); add_frame(0, w0, 4);
        push_q.push_back(w1); add_frame(0, w1, 8);
        chg_t = 10; chg_div = 8;
        play(0, 1 + 40 + 80 + 10);
        total++; if (first_bad !== -1) $display("FAIL div_change_line first bad sample %0d want none", first_bad); else passed++;
        start_stream();
        div[0] = 16'd0;
        push_q.push_back(w1); add_frame(0, w1, 0);
        play(0, 20);
        total++; if (first_bad !== -1) $display("FAIL div_zero_line first bad sample %0d want none", first_bad); else passed++;
        total++; if (busy[0] !== 1'b0) $display("FAIL div_zero_busy got %b want 0", busy[0]); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] w;
        int bad = 0;
        start_stream();
        div[0] = 16'd8;
        w = 9'($urandom_range(0, 255)) & 9'h0FD;
        push_q.push_back(w); add_frame(0, w, 8);
        for (int n = 0; n < 3; n++) push_q.push_back(9'($urandom_range(0, 255)));
        play(0, 22);
        total++; if (out[0] !== 1'b0) $display("FAIL mid_frame_bit got %b want 0", out[0]); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (out[0] !== 1'b1) $display("FAIL async_reset_out got %b want 1", out[0]); else passed++;
        total++; if (cnt[0] !== 3'd0) $display("FAIL async_reset_count got %0d want 0", cnt[0]); else passed++;
        total++; if (ready[0] !== 1'b1) $display("FAIL async_reset_ready got %b want 1", ready[0]); else passed++;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 3'd0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL post_reset_quiet active cycles %0d want 0", bad); else passed++;
        start_stream();
        w = 9'($urandom_range(0, 255));
        push_q.push_back(w); add_frame(0, w, 8);
        play(0, 1 + 80 + 10);
        total++; if (first_bad !== -1) $display("FAIL post_reset_frame first bad sample %0d want none", first_bad); else passed++;
    endtask

    task automatic test_width();
        logic [8:0] w;
        start_stream();
        div[3] = 16'd2;
        push_q.push_back(9'h0FF); add_frame(3, 9'h0FF, 2);
        for (int n = 0; n < 2; n++) begin
            w = 9'($urandom_range(0, 511));
            push_q.push_back(w); add_frame(3, w, 2);
        end
        play(3, 1 + 3 * 14 + 10);
        total++; if (first_bad !== -1) $display("FAIL width5_line first bad sample %0d want none", first_bad); else passed++;
        total++; if (busy[3] !== 1'b0) $display("FAIL width5_busy got %b want 0", busy[3]); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] w;
        int d;
        for (int i = 0; i < 4; i++) begin
            start_stream();
            d = int'($urandom_range(1, 5));
            div[i] = 16'(d);
            for (int n = 0; n < 4; n++) begin
                w = 9'($urandom_range(0, 511));
                push_q.push_back(w); add_frame(i, w, d);
            end
            play(i, 1 + 4 * 13 * d + 10);
            total++; if (first_bad !== -1) $display("FAIL b2b_line[%0d] div %0d first bad sample %0d want none", i, d, first_bad); else passed++;
            total++; if (busy[i] !== 1'b0) $display("FAIL b2b_busy[%0d] got %b want 0", i, busy[i]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_fifo_full();
        test_div_change();
        test_reset_mid_frame();
        test_width();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
